// File: rtl/top_pkg.sv
// Shared geometry, derived widths, FSM states and operand extension for the matrix-vector top.
// SIGNED_ARITH_EN selects two's complement operands; otherwise everything is unsigned.
package top_pkg;

    localparam int KERNEL_SIZE  = 3;
    localparam int DATA_WIDTH   = 8;
    localparam int WEIGHT_WIDTH = 8;
    localparam int DEPTH        = 4;
    localparam int PTR_WIDTH    = 2;
    localparam int BUS_WIDTH    = 32;

    localparam int SUM_WIDTH            = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE;
    localparam int DATAOUT_WIDTH        = SUM_WIDTH * KERNEL_SIZE;
    localparam int NUM_WEIGHT_TRANSFERS =
        (WEIGHT_WIDTH * KERNEL_SIZE * KERNEL_SIZE + BUS_WIDTH - 1) / BUS_WIDTH;

    typedef enum logic {
        LOAD_W = 1'b0,
        RUN    = 1'b1
    } state_e;

    // Products are formed at full sum width, so extension here makes the
    // modular multiply exact in both signed and unsigned modes.
    function automatic logic [SUM_WIDTH-1:0] ext_data(input logic [DATA_WIDTH-1:0] v);
`ifdef SIGNED_ARITH_EN
        return {{(SUM_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
`else
        return {{(SUM_WIDTH-DATA_WIDTH){1'b0}}, v};
`endif
    endfunction

    function automatic logic [SUM_WIDTH-1:0] ext_weight(input logic [WEIGHT_WIDTH-1:0] v);
`ifdef SIGNED_ARITH_EN
        return {{(SUM_WIDTH-WEIGHT_WIDTH){v[WEIGHT_WIDTH-1]}}, v};
`else
        return {{(SUM_WIDTH-WEIGHT_WIDTH){1'b0}}, v};
`endif
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Input beat FIFO with registered full/empty flags; head is read combinationally.
// A push while full is dropped, so callers gate push with !full_o; a pop while empty is ignored.
module stream_fifo #(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2,
    parameter int WIDTH     = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_WIDTH:0]   cnt_q, cnt_d;
    logic                 push_ok, pop_ok;

    assign full_o     = (cnt_q == (PTR_WIDTH+1)'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (PTR_WIDTH+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_WIDTH+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + PTR_WIDTH'(1);
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/top.sv
// Streaming KxK matrix-vector multiplier: weight load, then one W*b column out per input beat.
// Latency 2 edges from FIFO-empty acceptance; output stall freezes the pipeline, FIFO fills, then tready drops.
// SIGNED_ARITH_EN switches operands to two's complement.
module top
    import top_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [BUS_WIDTH-1:0]     s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     m_axis_tready,
    output logic [DATAOUT_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid
);

    localparam int K      = KERNEL_SIZE;
    localparam int KK     = K * K;
    localparam int SLICES = BUS_WIDTH / WEIGHT_WIDTH;
    localparam int WCNT_W = (NUM_WEIGHT_TRANSFERS > 1) ? $clog2(NUM_WEIGHT_TRANSFERS) : 1;

    state_e                   state_q, state_d;
    logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
    logic                     alive_q;
    logic [WEIGHT_WIDTH-1:0]  w_q [KK];

    logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [BUS_WIDTH-1:0]     fifo_dat;

    logic                     s1_vld_q;
    logic [SUM_WIDTH-1:0]     prod_q [KK];
    logic [SUM_WIDTH-1:0]     prod_d [KK];
    logic                     m_vld_q;
    logic [DATAOUT_WIDTH-1:0] m_dat_q, m_dat_d;
    logic                     advance, w_beat;

    // alive_q keeps tready low while reset is asserted and for the first edge after it.
    assign s_axis_tready = alive_q && ((state_q == LOAD_W) || !fifo_full);
    assign w_beat        = s_axis_tvalid && s_axis_tready && (state_q == LOAD_W);
    assign fifo_push     = s_axis_tvalid && s_axis_tready && (state_q == RUN);
    assign advance       = !(m_vld_q && !m_axis_tready);
    assign fifo_pop      = advance && !fifo_empty;
    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tdata  = m_dat_q;

    stream_fifo #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .WIDTH     (BUS_WIDTH)
    ) u_in_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push_i     (fifo_push),
        .push_dat_i (s_axis_tdata),
        .pop_i      (fifo_pop),
        .head_dat_o (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (w_beat) begin
            if (wcnt_q == WCNT_W'(NUM_WEIGHT_TRANSFERS - 1)) state_d = RUN;
            else                                             wcnt_d  = wcnt_q + WCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= LOAD_W;
            wcnt_q  <= '0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            alive_q <= 1'b1;
        end
    end

    // Element e lives in beat e/SLICES, MSB-first slice e%SLICES; row-major into W.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int e = 0; e < KK; e++) w_q[e] <= '0;
        end else if (w_beat) begin
            for (int e = 0; e < KK; e++) begin
                if (wcnt_q == WCNT_W'(e / SLICES))
                    w_q[e] <= s_axis_tdata[BUS_WIDTH-1-(e%SLICES)*WEIGHT_WIDTH -: WEIGHT_WIDTH];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int i = 0; i < K; i++) begin
                prod_d[r*K+i] = ext_weight(w_q[r*K+i])
                              * ext_data(fifo_dat[BUS_WIDTH-1-i*DATA_WIDTH -: DATA_WIDTH]);
            end
        end
    end

    always_comb begin
        m_dat_d = '0;
        for (int r = 0; r < K; r++) begin
            for (int i = 0; i < K; i++) begin
                m_dat_d[r*SUM_WIDTH +: SUM_WIDTH] = m_dat_d[r*SUM_WIDTH +: SUM_WIDTH] + prod_q[r*K+i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld_q <= 1'b0;
            m_vld_q  <= 1'b0;
            m_dat_q  <= '0;
            for (int e = 0; e < KK; e++) prod_q[e] <= '0;
        end else if (advance) begin
            s1_vld_q <= !fifo_empty;
            if (!fifo_empty) prod_q <= prod_d;
            m_vld_q <= s1_vld_q;
            if (s1_vld_q) m_dat_q <= m_dat_d;
        end
    end

endmodule

// File: tb/tb_top.sv
// Directed + randomized bench for top; a queue-based column model predicts every result.
module tb_top;
    import top_pkg::*;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic [BUS_WIDTH-1:0]     s_axis_tdata = '0;
    logic                     s_axis_tvalid = 1'b0;
    logic                     s_axis_tready;
    logic                     m_axis_tready = 1'b0;
    logic [DATAOUT_WIDTH-1:0] m_axis_tdata;
    logic                     m_axis_tvalid;

    top dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int delivered = 0;
    int wbeats = 0;
    int wm [KERNEL_SIZE*KERNEL_SIZE];
    logic [DATAOUT_WIDTH-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int el(input logic [7:0] v);
`ifdef SIGNED_ARITH_EN
        return int'($signed(v));
`else
        return int'({24'd0, v});
`endif
    endfunction

    function automatic logic [DATAOUT_WIDTH-1:0] pack3(input int c0, input int c1, input int c2);
        logic [DATAOUT_WIDTH-1:0] v;
        int t;
        t = c0; v[0*SUM_WIDTH +: SUM_WIDTH] = t[SUM_WIDTH-1:0];
        t = c1; v[1*SUM_WIDTH +: SUM_WIDTH] = t[SUM_WIDTH-1:0];
        t = c2; v[2*SUM_WIDTH +: SUM_WIDTH] = t[SUM_WIDTH-1:0];
        return v;
    endfunction

    // Reference: first beats fill W element by element, later beats yield c = W*b.
    task automatic model_accept(input logic [BUS_WIDTH-1:0] d);
        int c [KERNEL_SIZE];
        int n;
        if (wbeats < NUM_WEIGHT_TRANSFERS) begin
            for (int j = 0; j < BUS_WIDTH/WEIGHT_WIDTH; j++) begin
                n = wbeats * (BUS_WIDTH/WEIGHT_WIDTH) + j;
                if (n < KERNEL_SIZE*KERNEL_SIZE) wm[n] = el(d[BUS_WIDTH-1-j*WEIGHT_WIDTH -: WEIGHT_WIDTH]);
            end
            wbeats++;
        end else begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                c[r] = 0;
                for (int i = 0; i < KERNEL_SIZE; i++)
                    c[r] += wm[r*KERNEL_SIZE+i] * el(d[BUS_WIDTH-1-i*DATA_WIDTH -: DATA_WIDTH]);
            end
            exp_q.push_back(pack3(c[0], c[1], c[2]));
        end
    endtask

    // Called #1 after an edge: observe handshakes of the coming edge, then advance to it.
    task automatic cycle(output bit acc);
        acc = s_axis_tvalid && s_axis_tready;
        if (acc) model_accept(s_axis_tdata);
        if (m_axis_tvalid && m_axis_tready) begin
            delivered++;
            if (exp_q.size() == 0) check("unexpected_out", 64'(m_axis_tdata), 64'd0);
            else                   check("out_dat", 64'(m_axis_tdata), 64'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bit a;
        cycle(a);
    endtask

    task automatic send_beat(input logic [BUS_WIDTH-1:0] d);
        bit a;
        int t;
        a = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        for (t = 0; t < 50 && !a; t++) cycle(a);
        s_axis_tvalid = 1'b0;
        if (!a) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        tick();
        check("vld_drop", 64'(m_axis_tvalid), 64'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        wbeats = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
    endtask

    bit acc;
    int n_acc, n_sent, d0;
    logic [DATAOUT_WIDTH-1:0] held;
    logic [BUS_WIDTH-1:0] rd;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tdata",  64'(m_axis_tdata),  64'd0);
        rstn = 1'b1;
        tick();
        check("load_tready", 64'(s_axis_tready), 64'd1);

        // Weights 1..9 row-major, then three columns with known results.
        send_beat(32'h01020304);
        send_beat(32'h05060708);
        send_beat(32'h09000000);
        check("run_tready", 64'(s_axis_tready), 64'd1);
        m_axis_tready = 1'b1;
        send_beat(32'h0A0D1000);
        check("lat_e0", 64'(m_axis_tvalid), 64'd0);
        tick();
        check("lat_e1", 64'(m_axis_tvalid), 64'd0);
        tick();
        check("lat_e2", 64'(m_axis_tvalid), 64'd1);
        check("col0", 64'(m_axis_tdata), 64'(pack3(84, 201, 318)));
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h0B0E1100;
        cycle(acc);
        s_axis_tdata  = 32'h0C0F1200;
        cycle(acc);
        s_axis_tvalid = 1'b0;
        tick();
        check("col1", 64'(m_axis_tdata), 64'(pack3(90, 216, 342)));
        tick();
        check("col2", 64'(m_axis_tdata), 64'(pack3(96, 231, 366)));
        drain();

        // Stalled output: FIFO plus two pipeline stages absorb DEPTH+2 beats.
        m_axis_tready = 1'b0;
        n_acc = 0;
        rd = $urandom;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_axis_tdata = rd;
            cycle(acc);
            if (acc) begin
                n_acc++;
                rd = $urandom;
            end
        end
        s_axis_tvalid = 1'b0;
        check("bp_accepts", 64'(n_acc), 64'(DEPTH + 2));
        check("bp_tready", 64'(s_axis_tready), 64'd0);
        held = m_axis_tdata;
        check("bp_head", 64'(held), 64'(exp_q[0]));
        repeat (3) tick();
        check("bp_hold_dat", 64'(m_axis_tdata), 64'(held));
        check("bp_hold_vld", 64'(m_axis_tvalid), 64'd1);
        m_axis_tready = 1'b1;
        d0 = delivered;
        drain();
        check("bp_delivered", 64'(delivered - d0), 64'(DEPTH + 2));

        // Reset with two results in flight discards them and the weights.
        m_axis_tready = 1'b0;
        send_beat($urandom);
        send_beat($urandom);
        tick();
        tick();
        check("pend_vld", 64'(m_axis_tvalid), 64'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_vld", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_dat", 64'(m_axis_tdata), 64'd0);
        exp_q.delete();
        wbeats = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        check("post_rst_tready", 64'(s_axis_tready), 64'd1);

        // Random weights and traffic with random downstream stalls.
        for (int k = 0; k < NUM_WEIGHT_TRANSFERS; k++) send_beat($urandom);
        n_sent = 0;
        rd = $urandom;
        for (int t = 0; t < 600 && n_sent < 40; t++) begin
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            s_axis_tdata  = rd;
            m_axis_tready = ($urandom_range(0, 2) != 0);
            cycle(acc);
            if (acc) begin
                n_sent++;
                rd = $urandom;
            end
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        check("rand_sent", 64'(n_sent), 64'd40);
        drain();

        // All-ones operands.
        do_reset();
        for (int k = 0; k < NUM_WEIGHT_TRANSFERS; k++) send_beat(32'hFFFFFFFF);
        send_beat(32'hFFFFFF00);
        tick();
        tick();
`ifdef SIGNED_ARITH_EN
        check("max_vals", 64'(m_axis_tdata), 64'(pack3(3, 3, 3)));
`else
        check("max_vals", 64'(m_axis_tdata), 64'(pack3(195075, 195075, 195075)));
`endif
        drain();

`ifdef SIGNED_ARITH_EN
        do_reset();
        for (int k = 0; k < NUM_WEIGHT_TRANSFERS; k++) send_beat(32'hFFFFFFFF);
        send_beat(32'h01020300);
        tick();
        tick();
        check("signed_neg6", 64'(m_axis_tdata), 64'(pack3(-6, -6, -6)));
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/top.md
Name: top

Overview:
- Streaming 3x3 matrix-vector multiplier with an AXI4-Stream-style input and output.
- After reset, the first NUM_WEIGHT_TRANSFERS input beats load a KxK weight matrix W.
- Every later input beat carries one K-element column b, and the block emits one packed output column c = W·b.
- Sits between a DMA/stream source and a result sink as the compute top of the map-inflation accelerator.

Parameters:
- KERNEL_SIZE, 3, matrix dimension K.
- DATA_WIDTH, 8, bits per data element.
- WEIGHT_WIDTH, 8, bits per weight element.
- DEPTH, 4, input FIFO entries.
- PTR_WIDTH, 2, FIFO pointer width; equals log2(DEPTH).
- BUS_WIDTH, 32, input stream width.
- Derived: SUM_WIDTH = DATA_WIDTH+WEIGHT_WIDTH+KERNEL_SIZE.
- Derived: DATAOUT_WIDTH = SUM_WIDTH*K.
- Derived: NUM_WEIGHT_TRANSFERS = ceil(WEIGHT_WIDTH*K*K / BUS_WIDTH), which is 3 at the defaults.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  BUS_WIDTH  weight or data beat.
- s_axis_tvalid  in  1  source valid.
- s_axis_tready  out  1  sink ready.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATAOUT_WIDTH  packed result column.
- m_axis_tvalid  out  1  result valid.

Behaviour:
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0. W, FIFO, pipeline and counters are cleared. State is LOAD_W. Reset asserted mid-operation discards everything, including loaded weights.
- A beat transfers on any rising edge where tvalid && tready.
- States:
  - LOAD_W: s_axis_tready=1, beats counted 0..NUM_WEIGHT_TRANSFERS-1. On the last weight beat, go to RUN.
  - RUN: stays in RUN until reset.
- Weight packing:
  - Elements are taken MSB-first within each beat: bits [BUS_WIDTH-1 -: WEIGHT_WIDTH] first, then the next lower slice.
  - Numbering continues across beats.
  - Element n maps to W[n/K][n%K] (row-major).
  - Slices beyond K*K in the last beat are ignored.
- Data packing: b[i] = s_axis_tdata[BUS_WIDTH-1-i*DATA_WIDTH -: DATA_WIDTH] for i=0..K-1. Remaining low bits are ignored.
- RUN input path:
  - Beats enter a DEPTH-entry FIFO; s_axis_tready = !fifo_full.
  - A full FIFO with a simultaneous pop still reports full that cycle; no combinational tready path.
  - Pointers wrap modulo DEPTH; a separate count or extra bit distinguishes full from empty.
- Pipeline, 2 stages, one advance enable = !(m_axis_tvalid && !m_axis_tready):
  - Stage 1 pops the FIFO head when it is non-empty and registers all K*K products W[r][i]*b[i].
  - Stage 2 registers c[r] = Σ_i products into the output register and sets m_axis_tvalid.
- Latency: a beat accepted at edge N with an empty pipeline gives m_axis_tvalid high after edge N+2. Throughput is 1 column/cycle.
- Output hold: while m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tvalid hold stable and the whole pipeline freezes. The FIFO keeps accepting until full.
- m_axis_tvalid drops after acceptance if no new result is arriving.
- Output packing: c[r] occupies m_axis_tdata[r*SUM_WIDTH +: SUM_WIDTH] (row 0 in the LSBs).
- Arithmetic: unsigned by default, zero-extended to SUM_WIDTH. No overflow is possible (K products of max value fit).

Optional Feature:
- Macro SIGNED_ARITH_EN.
- Defined: data and weights are two's complement; products and sums are sign-extended to SUM_WIDTH.
- Undefined: all operands are unsigned, zero-extended.

Decomposition:
- Package top_pkg holds the derived localparams (SUM_WIDTH, DATAOUT_WIDTH, NUM_WEIGHT_TRANSFERS) and the state enum {LOAD_W, RUN}.
- One sub-module, stream_fifo (DEPTH/PTR_WIDTH, BUS_WIDTH wide, full/empty flags), instantiated for the input path.
- Weight registers, MAC pipeline and FSM stay in top.

Test Plan:
- Load weights: beats 0x01020304, 0x05060708, 0x09000000 -> internal W = [[1,2,3],[4,5,6],[7,8,9]], state RUN, s_axis_tready=1.
- Data beats 0x0A0D1000, 0x0B0E1100, 0x0C0F1200 with m_axis_tready=1 -> outputs c=(84,201,318), then (90,216,342), then (96,231,366). Each output is valid 2 edges after its input beat.
- Backpressure: m_axis_tready=0, stream 8 consecutive data beats -> exactly DEPTH+2=6 accepted, then s_axis_tready=0 and m_axis_tdata held constant. Release -> all 6 results delivered in order with none lost or duplicated.
- Max values: all weights and data 0xFF (unsigned) -> every lane = 195075.
- Reset mid-stream: assert rstn=0 with 2 results pending -> m_axis_tvalid=0 immediately. After release the block is back in LOAD_W and the next beat is treated as weight beat 0.
- SIGNED_ARITH_EN defined: weights all 0xFF (-1), data (1,2,3) -> every lane = -6 in SUM_WIDTH two's complement.
